// File: rtl/mem_if_pkg.sv
// Shared constants for the memory responder: default bus widths, read-latency
// bounds and the statistics counter type with its saturating increment.
package mem_if_pkg;

    localparam int MEM_AW_DEF = 16;
    localparam int MEM_DW_DEF = 32;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = 32;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters stick at all-ones instead of wrapping.
    function automatic cnt_t sat_inc(input cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port storage with a one-cycle registered read. Contents are not reset;
// only the read register is, so stale data never leaks out after a reset.
module mem_responder_ram #(
    parameter int AW = 10,
    parameter int DW = 32
)(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Register only moves on a read, so it holds the last result between reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: range check, RD_LAT-deep read pipeline around
// a 1-cycle RAM, and saturating access counters with a sticky range error.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int MEM_DW   = MEM_DW_DEF,
    parameter int DEPTH_AW = 10,
    parameter int RD_LAT   = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [MEM_AW-1:0] mem_addr,
    input  logic [MEM_DW-1:0] mem_wdata,
    output logic [MEM_DW-1:0] mem_rdata,
    output logic              mem_rvalid,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err
);

    logic              in_range;
    logic              acc;
    logic              rd_acc;
    logic              wr_acc;
    logic [MEM_DW-1:0] ram_rdata;
    logic [MEM_DW-1:0] s1_data;
    logic              oor_q;
    logic [RD_LAT:1]   vld_pipe_q;
    cnt_t              rd_cnt_q, rd_cnt_d;
    cnt_t              wr_cnt_q, wr_cnt_d;
    logic              err_q, err_d;

    always_comb begin
        in_range = ((mem_addr >> DEPTH_AW) == '0);
        acc      = mem_req & ~rst;
        rd_acc   = acc & ~mem_write;
        wr_acc   = acc & mem_write;
    end

    mem_responder_ram #(
        .AW (DEPTH_AW),
        .DW (MEM_DW)
    ) u_ram (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (wr_acc & in_range),
        .re_i    (rd_acc),
        .addr_i  (mem_addr[DEPTH_AW-1:0]),
        .wdata_i (mem_wdata),
        .rdata_o (ram_rdata)
    );

    // Out-of-range reads still go through the RAM (aliased address); the flag
    // travelling alongside replaces the word with zero at the RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            oor_q <= 1'b0;
        end else if (rd_acc) begin
            oor_q <= ~in_range;
        end
    end

    assign s1_data = oor_q ? '0 : ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_acc;
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
            end
        end
    end

    assign mem_rvalid = vld_pipe_q[RD_LAT];

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign mem_rdata = s1_data;
        end else begin : g_latn
            logic [RD_LAT:2][MEM_DW-1:0] stg_q;
            logic [RD_LAT:2][MEM_DW-1:0] stg_src;

            always_comb begin
                stg_src    = '0;
                stg_src[2] = s1_data;
                for (int k = 3; k <= RD_LAT; k++) begin
                    stg_src[k] = stg_q[k-1];
                end
            end

            // Inner stages shift freely; the output stage loads only on a retiring read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    stg_q <= '0;
                end else begin
                    for (int k = 2; k <= RD_LAT; k++) begin
                        if (k < RD_LAT || vld_pipe_q[k-1]) begin
                            stg_q[k] <= stg_src[k];
                        end
                    end
                end
            end

            assign mem_rdata = stg_q[RD_LAT];
        end
    endgenerate

    // A clear in the same cycle as an access wins over the count and the error.
    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        if (clr_stats) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            err_d    = 1'b0;
        end else begin
            if (rd_acc) rd_cnt_d = sat_inc(rd_cnt_q);
            if (wr_acc) wr_cnt_d = sat_inc(wr_cnt_q);
            if (acc && !in_range) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scenarios plus a random stream, each cycle compared against a
// queue-based model of the responder's observable behaviour.
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int DAW = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic          clr_stats = 1'b0;
    logic [DW-1:0] mem_rdata;
    logic          mem_rvalid;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;
    logic          err;

    mem_responder #(
        .MEM_AW   (AW),
        .MEM_DW   (DW),
        .DEPTH_AW (DAW),
        .RD_LAT   (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .clr_stats  (clr_stats),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          due;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] mdl_mem [int];
    rd_t           pend [$];
    logic [31:0]   m_rd = 0;
    logic [31:0]   m_wr = 0;
    logic          m_err = 0;
    logic [DW-1:0] m_rdata = 0;
    logic          m_rvalid = 0;
    int            cyc = 0;
    logic [DW-1:0] cap [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, advance the model by the same cycle, compare all outputs.
    task automatic step(input logic req, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic clr, input logic r);
        logic inr;
        rd_t  e;
        mem_req   = req;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        clr_stats = clr;
        rst       = r;
        @(posedge clk);
        inr = ((addr >> DAW) == 0);
        if (r) begin
            m_rd = 0; m_wr = 0; m_err = 0; m_rdata = 0;
            pend.delete();
        end else begin
            if (clr) begin
                m_rd = 0; m_wr = 0; m_err = 0;
            end else if (req) begin
                if (wr) m_wr = (m_wr == 32'hFFFFFFFF) ? m_wr : m_wr + 1;
                else    m_rd = (m_rd == 32'hFFFFFFFF) ? m_rd : m_rd + 1;
                if (!inr) m_err = 1;
            end
            if (req && wr && inr) mdl_mem[int'(addr)] = wd;
            if (req && !wr) begin
                e.due  = cyc + LAT;
                e.data = inr ? mdl_mem[int'(addr)] : '0;
                pend.push_back(e);
            end
        end
        cyc++;
        m_rvalid = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_rvalid = 1;
            m_rdata  = pend[0].data;
            void'(pend.pop_front());
        end
        #1;
        chk("rvalid",   {31'b0, mem_rvalid}, {31'b0, m_rvalid});
        chk("rdata",    mem_rdata, m_rdata);
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
        chk("err",      {31'b0, err}, {31'b0, m_err});
        if (mem_rvalid) cap.push_back(mem_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic wr_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 1'b0);
    endtask

    task automatic rd_w(input logic [AW-1:0] a);
        step(1'b1, 1'b0, a, '0, 1'b0, 1'b0);
    endtask

    logic [DW-1:0] av [4];
    logic [DW-1:0] bv [4];
    logic [DW-1:0] cg [4];
    logic [DW-1:0] ca [4];
    logic [DW-1:0] cb [4];
    logic [AW-1:0] ra;
    int            rr;

    initial begin
        // reset state
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle(1);

        // write then read-after-write
        cap.delete();
        wr_w(16'h0005, 32'hDEADBEEF);
        rd_w(16'h0005);
        idle(3);
        chk("raw_cnt", {31'b0, cap.size() == 1}, 32'd1);
        if (cap.size() > 0) chk("raw_data", cap[0], 32'hDEADBEEF);
        chk("raw_wr", wr_count, 32'd1);
        chk("raw_rd", rd_count, 32'd1);

        // preload the low region so every in-range read below has known data
        for (int i = 0; i < 32; i++) wr_w(AW'(i), $urandom);

        // back-to-back reads
        for (int i = 0; i < 4; i++) wr_w(AW'(16'h10 + i), DW'(i + 1));
        cap.delete();
        for (int i = 0; i < 4; i++) rd_w(AW'(16'h10 + i));
        idle(3);
        chk("b2b_cnt", cap.size(), 32'd4);
        for (int i = 0; i < 4 && i < cap.size(); i++) chk("b2b_data", cap[i], DW'(i + 1));

        // out-of-range write and read
        cap.delete();
        wr_w(16'h0400, 32'h55);
        rd_w(16'h0400);
        rd_w(16'h0000);
        idle(4);
        chk("oor_err", {31'b0, err}, 32'd1);
        if (cap.size() > 0) chk("oor_data", cap[0], 32'd0);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        chk("oor_clr", {31'b0, err}, 32'd0);

        // reset with reads in flight; storage persists
        rd_w(16'h0010);
        rd_w(16'h0011);
        rd_w(16'h0012);
        cap.delete();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle(4);
        chk("rst_norv", cap.size(), 32'd0);
        chk("rst_data", mem_rdata, 32'd0);
        cap.delete();
        rd_w(16'h0010);
        idle(3);
        if (cap.size() > 0) chk("rst_keep", cap[0], 32'd1);
        else chk("rst_keep_cnt", cap.size(), 32'd1);

        // clear together with a write; counter saturation
        rd_w(16'h0003);
        wr_w(16'h0400, 32'h1);
        step(1'b1, 1'b1, 16'h0007, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("clr_rd", rd_count, 32'd0);
        chk("clr_wr", wr_count, 32'd0);
        chk("clr_err", {31'b0, err}, 32'd0);
        cap.delete();
        rd_w(16'h0007);
        idle(3);
        if (cap.size() > 0) chk("clr_store", cap[0], 32'hCAFEF00D);
        force dut.rd_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.rd_cnt_q;
        m_rd = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) rd_w(AW'(i));
        idle(2);
        chk("sat_rd", rd_count, 32'hFFFFFFFF);
        step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);

        // 2x2 matrix multiply through the memory
        for (int i = 0; i < 4; i++) begin
            av[i] = DW'($urandom_range(0, 255));
            bv[i] = DW'($urandom_range(0, 255));
            wr_w(AW'(16'h20 + i), av[i]);
        end
        for (int i = 0; i < 4; i++) wr_w(AW'(16'h24 + i), bv[i]);
        cap.delete();
        for (int i = 0; i < 8; i++) rd_w(AW'(16'h20 + i));
        idle(3);
        chk("mm_cnt", cap.size(), 32'd8);
        for (int i = 0; i < 4; i++) begin
            ca[i] = (cap.size() == 8) ? cap[i]     : '0;
            cb[i] = (cap.size() == 8) ? cap[i + 4] : '0;
        end
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                cg[i*2+j] = av[i*2] * bv[j] + av[i*2+1] * bv[2+j];
                wr_w(AW'(16'h28 + i*2 + j), ca[i*2] * cb[j] + ca[i*2+1] * cb[2+j]);
            end
        cap.delete();
        for (int i = 0; i < 4; i++) rd_w(AW'(16'h28 + i));
        idle(3);
        chk("mm_rcnt", cap.size(), 32'd4);
        for (int i = 0; i < 4 && i < cap.size(); i++) chk("mm_c", cap[i], cg[i]);

        // random traffic, including idle-cycle write noise, clears and resets
        for (int n = 0; n < 400; n++) begin
            rr = $urandom_range(0, 99);
            if ($urandom_range(0, 99) < 85) ra = AW'($urandom_range(0, 31));
            else begin
                ra = AW'($urandom);
                if ((ra >> DAW) == 0) ra[AW-1] = 1'b1;
            end
            step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 40, ra, $urandom,
                 rr >= 2 && rr < 6, rr < 2);
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
